// File: rtl/pio_pulse_out_if.sv
// -----------------------------------------------------------------------------
// pio_pulse_out_if
// Avalon-MM slave bus bundle for the pio_pulse_out output port.
//   address    : word address of the register being accessed
//   chipselect : slave select, qualifies write_n
//   write_n    : active-low write strobe
//   writedata  : write data from the master
//   readdata   : registered read data returned by the slave
// The master modport is used by the bus owner (CPU or testbench), the slave
// modport by the peripheral.
// -----------------------------------------------------------------------------
interface pio_pulse_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_pulse_out.sv
// -----------------------------------------------------------------------------
// pio_pulse_out
// Avalon-MM output port with a level register (atomic SET/CLEAR) and a
// hardware one-shot engine that forces selected bits high for a programmed
// number of cycles, then raises a sticky done flag and an optional interrupt.
//
// Parameters:
//   WIDTH       : number of output bits (1..32)
//   CNT_W       : pulse-length counter width (1..32)
//   RESET_VALUE : reset value of the DATA register (and thus of out_port)
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata)
//   out_port : driven output pins = data | pmask (registered)
//   irq      : level interrupt = done & irq_en (registered)
//
// Register map (word addresses):
//   0 DATA      r/w level register
//   1 SET       w   data |= wd ; reads 0
//   2 CLEAR     w   data &= ~wd ; reads 0
//   3 PULSE_LEN r/w pulse length (0 behaves as 1)
//   4 PULSE     w starts/retriggers (mask != 0) or aborts (mask == 0);
//               r returns the active pulse mask
//   5 STATUS    r {irq_en, done, busy}; w bit1=1 clears done, bit2 -> irq_en
//   6,7         reserved, read 0
// -----------------------------------------------------------------------------
module pio_pulse_out #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_pulse_out_if.slave       bus,
    output logic [WIDTH-1:0]     out_port,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_LEN    = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // A programmed length of zero still yields a one-cycle pulse.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] l);
        logic [CNT_W-1:0] r;
        if (l == {CNT_W{1'b0}}) begin
            r = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = l;
        end
        return r;
    endfunction

    // Architectural state
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] len_r;
    logic [WIDTH-1:0] pmask_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic             irq_en_r;
    logic [31:0]      readdata_r;
    logic [WIDTH-1:0] out_port_r;
    logic             irq_r;

    // Next-state values
    logic [WIDTH-1:0] data_nxt_s;
    logic [CNT_W-1:0] len_nxt_s;
    logic [WIDTH-1:0] pmask_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             done_nxt_s;
    logic             irq_en_nxt_s;
    logic [31:0]      rd_mux_s;

    // Decoded bus strobes
    logic             wr_s;
    logic [WIDTH-1:0] wmask_s;
    logic             busy_s;
    logic             done_set_s;
    logic             unused_wd_s;

    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wmask_s     = bus.writedata[WIDTH-1:0];
    assign busy_s      = (cnt_r != {CNT_W{1'b0}});
    // Upper write-data bits are intentionally ignored for narrow configurations.
    assign unused_wd_s = ^bus.writedata;

    // Level register: DATA, SET and CLEAR writes; never touched by the pulse engine.
    always_comb begin
        data_nxt_s = data_r;
        if (wr_s) begin
            case (bus.address)
                ADDR_DATA:  data_nxt_s = wmask_s;
                ADDR_SET:   data_nxt_s = data_r | wmask_s;
                ADDR_CLEAR: data_nxt_s = data_r & ~wmask_s;
                default:    data_nxt_s = data_r;
            endcase
        end else begin
            data_nxt_s = data_r;
        end
    end

    // Pulse length register; a change only affects later PULSE writes.
    always_comb begin
        len_nxt_s = len_r;
        if (wr_s && (bus.address == ADDR_LEN)) begin
            len_nxt_s = bus.writedata[CNT_W-1:0];
        end else begin
            len_nxt_s = len_r;
        end
    end

    // Pulse engine: a PULSE write has priority over expiry, so a retrigger on
    // the final cycle extends the pulse instead of completing it.
    always_comb begin
        pmask_nxt_s = pmask_r;
        cnt_nxt_s   = cnt_r;
        done_set_s  = 1'b0;
        if (wr_s && (bus.address == ADDR_PULSE)) begin
            if (wmask_s != {WIDTH{1'b0}}) begin
                pmask_nxt_s = pmask_r | wmask_s;
                cnt_nxt_s   = eff_len(len_r);
            end else begin
                // Abort: drop everything without signalling completion.
                pmask_nxt_s = {WIDTH{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        end else if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            pmask_nxt_s = {WIDTH{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            done_set_s  = 1'b1;
        end else if (busy_s) begin
            cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pmask_nxt_s = pmask_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // Sticky done flag (set beats a same-cycle clear) and interrupt enable.
    always_comb begin
        done_nxt_s   = done_r;
        irq_en_nxt_s = irq_en_r;
        if (done_set_s) begin
            done_nxt_s = 1'b1;
        end else if (wr_s && (bus.address == ADDR_STATUS) && bus.writedata[1]) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        if (wr_s && (bus.address == ADDR_STATUS)) begin
            irq_en_nxt_s = bus.writedata[2];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // Read mux on the current address using pre-write register contents.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (bus.address)
            ADDR_DATA:   rd_mux_s[WIDTH-1:0] = data_r;
            ADDR_LEN:    rd_mux_s[CNT_W-1:0] = len_r;
            ADDR_PULSE:  rd_mux_s[WIDTH-1:0] = pmask_r;
            ADDR_STATUS: rd_mux_s[2:0]       = {irq_en_r, done_r, busy_s};
            default:     rd_mux_s            = 32'h0000_0000;
        endcase
    end

    // State and output registers. out_port and irq are registered copies of
    // the next-state combination so they move together with data/pmask/done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r     <= RESET_VALUE;
            len_r      <= {{(CNT_W-1){1'b0}}, 1'b1};
            pmask_r    <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            done_r     <= 1'b0;
            irq_en_r   <= 1'b0;
            readdata_r <= 32'h0000_0000;
            out_port_r <= RESET_VALUE;
            irq_r      <= 1'b0;
        end else begin
            data_r     <= data_nxt_s;
            len_r      <= len_nxt_s;
            pmask_r    <= pmask_nxt_s;
            cnt_r      <= cnt_nxt_s;
            done_r     <= done_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            readdata_r <= rd_mux_s;
            out_port_r <= data_nxt_s | pmask_nxt_s;
            irq_r      <= done_nxt_s & irq_en_nxt_s;
        end
    end

    assign bus.readdata = readdata_r;
    assign out_port     = out_port_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_pio_pulse_out.sv
// -----------------------------------------------------------------------------
// tb_pio_pulse_out
// Scoreboard bench for pio_pulse_out (WIDTH=8, CNT_W=16, RESET_VALUE=8'hA5).
// The stimulus process drives one bus cycle per clock, advances a reference
// model that tracks pulses by their absolute end cycle, and pushes the
// expected readdata/out_port/irq for that cycle; the monitor pops and compares
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_pio_pulse_out;

    localparam int         W  = 8;
    localparam int         CW = 16;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] out_port;
    logic         irq;

    pio_pulse_out_if bus ();

    pio_pulse_out #(.WIDTH(W), .CNT_W(CW), .RESET_VALUE(RV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  op;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    logic [7:0]  m_data;
    logic [15:0] m_len;
    logic [7:0]  m_pmask;
    bit          m_active;
    longint      m_end;
    bit          m_done;
    bit          m_irq_en;
    longint      edge_k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data   = RV;
        m_len    = 16'd1;
        m_pmask  = 8'h00;
        m_active = 1'b0;
        m_end    = 0;
        m_done   = 1'b0;
        m_irq_en = 1'b0;
    endtask

    // One clock edge of the reference model.
    task automatic model_step(input bit wr, input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        bit   done_set;
        e.rd = 32'h0;
        case (a)
            3'd0: e.rd = {24'h0, m_data};
            3'd3: e.rd = {16'h0, m_len};
            3'd4: e.rd = {24'h0, m_pmask};
            3'd5: e.rd = {29'h0, m_irq_en, m_done, m_active};
            default: e.rd = 32'h0;
        endcase
        done_set = 1'b0;
        if (wr && a == 3'd4) begin
            if (wd[7:0] != 8'h00) begin
                m_pmask  = m_pmask | wd[7:0];
                m_active = 1'b1;
                m_end    = edge_k + ((m_len == 16'd0) ? 1 : longint'(m_len));
            end else begin
                m_pmask  = 8'h00;
                m_active = 1'b0;
            end
        end else if (m_active && edge_k == m_end) begin
            m_pmask  = 8'h00;
            m_active = 1'b0;
            done_set = 1'b1;
        end
        if (wr) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_data = m_data | wd[7:0];
                3'd2: m_data = m_data & ~wd[7:0];
                3'd3: m_len  = wd[15:0];
                3'd5: m_irq_en = wd[2];
                default: ;
            endcase
        end
        if (done_set) m_done = 1'b1;
        else if (wr && a == 3'd5 && wd[1]) m_done = 1'b0;
        e.op  = m_data | m_pmask;
        e.irq = m_done & m_irq_en;
        q.push_back(e);
    endtask

    task automatic bus_cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        @(posedge clk);
        edge_k++;
        model_step(cs & ~wn, a, wd);
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        bus_cycle(1'b1, 1'b0, a, wd);
    endtask

    // Idle/read cycle: chipselect toggles randomly, never a write.
    task automatic rd_reg(input logic [2:0] a);
        bus_cycle(1'($urandom_range(0, 1)), 1'b1, a, $urandom);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && q.size() > 0) begin
            e = q.pop_front();
            check("readdata", bus.readdata, e.rd);
            check("out_port", {24'h0, out_port}, {24'h0, e.op});
            check("irq", {31'h0, irq}, {31'h0, e.irq});
        end
    end

    initial begin
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_port", {24'h0, out_port}, {24'h0, RV});
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;

        // Reset-state readback
        rd_reg(3'd5); rd_reg(3'd3); rd_reg(3'd0);

        // Level register with atomic set/clear
        wr_reg(3'd0, 32'h0000_000F);
        wr_reg(3'd1, 32'h0000_0030);
        wr_reg(3'd2, 32'h0000_0003);
        rd_reg(3'd0); rd_reg(3'd1); rd_reg(3'd2);
        wr_reg(3'd0, 32'h0000_0000);

        // 5-cycle pulse with interrupt, then clear done keeping irq_en
        wr_reg(3'd3, 32'd5);
        wr_reg(3'd5, 32'h4);
        wr_reg(3'd4, 32'h81);
        repeat (7) rd_reg(3'd5);
        wr_reg(3'd5, 32'h6);
        rd_reg(3'd5); rd_reg(3'd5);

        // Retrigger extends both bits; a single done at the end
        wr_reg(3'd5, 32'h2);
        wr_reg(3'd3, 32'd4);
        wr_reg(3'd4, 32'h01);
        rd_reg(3'd4);
        wr_reg(3'd4, 32'h02);
        repeat (6) rd_reg(3'd4);
        rd_reg(3'd5);
        wr_reg(3'd5, 32'h2);

        // Zero length behaves as one cycle
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd4, 32'h10);
        repeat (3) rd_reg(3'd5);
        wr_reg(3'd5, 32'h2);

        // Abort after three cycles: no done
        wr_reg(3'd3, 32'd10);
        wr_reg(3'd4, 32'h10);
        repeat (3) rd_reg(3'd5);
        wr_reg(3'd4, 32'h0);
        repeat (3) rd_reg(3'd5);

        // Clear-done on the expiry edge: set wins
        wr_reg(3'd3, 32'd3);
        wr_reg(3'd4, 32'h01);
        rd_reg(3'd5); rd_reg(3'd5);
        wr_reg(3'd5, 32'h2);
        rd_reg(3'd5); rd_reg(3'd5);

        // Length truncated to CNT_W bits
        wr_reg(3'd3, 32'h0001_0002);
        rd_reg(3'd3);
        wr_reg(3'd4, 32'h40);
        repeat (4) rd_reg(3'd5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            logic        cs;
            logic        wn;
            a  = 3'($urandom_range(0, 7));
            cs = 1'($urandom_range(0, 3) != 0);
            wn = 1'($urandom_range(0, 2) == 0);
            wd = $urandom;
            if (a == 3'd3) wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
            if (a == 3'd4 && $urandom_range(0, 7) == 0) wd = wd & 32'hFFFF_FF00;
            bus_cycle(cs, wn, a, wd);
        end

        // Reset asserted mid-pulse
        wr_reg(3'd0, 32'h0000_0000);
        wr_reg(3'd3, 32'd10);
        wr_reg(3'd4, 32'h0F);
        rd_reg(3'd4); rd_reg(3'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_port", {24'h0, out_port}, {24'h0, RV});
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        q.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(3'd5);
        repeat (12) rd_reg(3'd5);
        rd_reg(3'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
